// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC that turns a signed (x, y)
// point into angle = atan2(y, x) in Q3.13 radians and a magnitude.
// The engine performs one micro-rotation per clock and uses a start/done handshake.
// Optional feature macro CORDIC_VEC_GAIN_COMP_EN: adds a SCALE state that
// multiplies the result by 1/K, so that magnitude is the true vector length.
// When the macro is not defined, magnitude carries the CORDIC gain K ~ 1.64676.
module cordic_vectoring #(
    parameter int ITERS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] angle,
    output logic        [16:0] magnitude
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FOLD  = 3'd1,
        S_ITER  = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);
    localparam logic signed [15:0] HALF_PI = 16'sd12868;

    // Elementary rotation angles atan(2^-i) in Q3.13.
    function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
        logic signed [15:0] val;
        case (idx)
            4'd0:    val = 16'sd6434;
            4'd1:    val = 16'sd3798;
            4'd2:    val = 16'sd2007;
            4'd3:    val = 16'sd1019;
            4'd4:    val = 16'sd511;
            4'd5:    val = 16'sd256;
            4'd6:    val = 16'sd128;
            4'd7:    val = 16'sd64;
            4'd8:    val = 16'sd32;
            4'd9:    val = 16'sd16;
            4'd10:   val = 16'sd8;
            4'd11:   val = 16'sd4;
            4'd12:   val = 16'sd2;
            4'd13:   val = 16'sd1;
            default: val = 16'sd0;
        endcase
        return val;
    endfunction

    state_t             state_q, state_d;
    logic signed [17:0] x_q, x_d;
    logic signed [17:0] y_q, y_d;
    logic signed [15:0] z_q, z_d;
    logic        [3:0]  i_q, i_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [15:0] angle_q, angle_d;
    logic        [16:0] mag_q, mag_d;

    logic signed [17:0] x_sh_s;
    logic signed [17:0] y_sh_s;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic signed [33:0] prod_s;
`endif

    // Next-state and datapath computation for every state of the engine.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        angle_d = angle_q;
        mag_d   = mag_q;
        x_sh_s  = x_q >>> i_q;
        y_sh_s  = y_q >>> i_q;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        // 19899 = 0.60725 in Q0.15, i.e. the inverse of the CORDIC gain.
        prod_s  = x_q * 16'sd19899;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = {{2{x_in[15]}}, x_in};
                    y_d     = {{2{y_in[15]}}, y_in};
                    i_d     = 4'd0;
                    // atan2(0,0) is undefined; the iteration would accumulate
                    // all atan steps, so the angle is forced to zero instead.
                    zero_d  = (x_in == 16'sd0) && (y_in == 16'sd0);
                    busy_d  = 1'b1;
                    state_d = S_FOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FOLD: begin
                // Rotate left-half-plane points by +/-90 degrees into x >= 0.
                if (!x_q[17]) begin
                    z_d = 16'sd0;
                end else if (!y_q[17]) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = HALF_PI;
                end else begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = -HALF_PI;
                end
                state_d = S_ITER;
            end
            S_ITER: begin
                // Rotate toward the x axis; z accumulates the rotated angle.
                if (!y_q[17]) begin
                    x_d = x_q + y_sh_s;
                    y_d = y_q - x_sh_s;
                    z_d = z_q + atan_lut(i_q);
                end else begin
                    x_d = x_q - y_sh_s;
                    y_d = y_q + x_sh_s;
                    z_d = z_q - atan_lut(i_q);
                end
                i_d = i_q + 4'd1;
                if (i_q == LAST_ITER) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_ITER;
                end
            end
            S_SCALE: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                x_d = 18'(prod_s >>> 15);
`else
                x_d = x_q;
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                angle_d = zero_q ? 16'sd0 : z_q;
                mag_d   = x_q[16:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= 18'sd0;
            y_q     <= 18'sd0;
            z_q     <= 16'sd0;
            i_q     <= 4'd0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            angle_q <= 16'sd0;
            mag_q   <= 17'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign angle     = angle_q;
    assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: stimulus pushes reference results
// computed with real-valued atan2/sqrt; a monitor pops and compares on done.
module tb_cordic_vectoring;

    localparam int ITERS = 12;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT  = ITERS + 3;
    localparam real GAIN = 1.0;
`else
    localparam int  LAT  = ITERS + 2;
    localparam real GAIN = 1.6467602;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               busy;
    logic               done;
    logic signed [15:0] angle;
    logic        [16:0] magnitude;

    cordic_vectoring #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .angle     (angle),
        .magnitude (magnitude)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ang;
        int mag;
        int ang_tol;
        int mag_tol;
        int issue;
        int xv;
        int yv;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: polar conversion straight from the mathematical definition.
    function automatic void model(input int xv, input int yv, output int ang, output int mag);
        real a;
        real r;
        if (xv == 0 && yv == 0) begin
            ang = 0;
            mag = 0;
        end else begin
            a   = $atan2(real'(yv), real'(xv)) * 8192.0;
            ang = $rtoi(a >= 0.0 ? a + 0.5 : a - 0.5);
            r   = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
            mag = $rtoi(r * GAIN + 0.5);
        end
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1'b0, 1, 0);
            end else begin
                exp_t e;
                int   d;
                int   ma;
                e  = sb.pop_front();
                d  = int'(angle) - e.ang;
                if (d > 25736)  d -= 51472;
                if (d < -25736) d += 51472;
                if (d < 0) d = -d;
                chk($sformatf("angle(%0d,%0d)", e.xv, e.yv), d <= e.ang_tol, int'(angle), e.ang);
                ma = int'({15'd0, magnitude}) - e.mag;
                if (ma < 0) ma = -ma;
                chk($sformatf("magnitude(%0d,%0d)", e.xv, e.yv), ma <= e.mag_tol,
                    int'({15'd0, magnitude}), e.mag);
                chk($sformatf("latency(%0d,%0d)", e.xv, e.yv), (cyc - e.issue) == LAT,
                    cyc - e.issue, LAT);
                chk("busy_low_at_done", busy == 1'b0, int'(busy), 0);
            end
        end
    end

    // Caller is positioned at a negedge; start is sampled by the next posedge.
    task automatic issue(input int xv, input int yv, input bit expect_it, input int at, input int mt);
        exp_t e;
        int   a;
        int   m;
        start = 1'b1;
        x_in  = 16'(xv);
        y_in  = 16'(yv);
        if (expect_it) begin
            model(xv, yv, a, m);
            e.ang = a; e.mag = m; e.ang_tol = at; e.mag_tol = mt;
            e.issue = cyc + 1; e.xv = xv; e.yv = yv;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy == 1'b1, int'(busy), 1);
    endtask

    // Returns at the negedge where done is seen, or flags a timeout.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
        end
        chk("done_timeout", seen, int'(seen), 1);
    endtask

    int dir_x[10] = '{16384, 11585, -16384, 0, -11585, 0, -32768, -32768, 0, 32767};
    int dir_y[10] = '{0, 11585, 0, -16384, -11585, 0, -32768, 0, -32768, 32767};

    initial begin
        int xv;
        int yv;
        rst_n = 1'b0;
        start = 1'b0;
        x_in  = 16'sd0;
        y_in  = 16'sd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy == 1'b0, int'(busy), 0);
        chk("reset_done", done == 1'b0, int'(done), 0);
        chk("reset_angle", angle == 16'sd0, int'(angle), 0);
        chk("reset_magnitude", magnitude == 17'd0, int'({15'd0, magnitude}), 0);

        // First start on the very first edge after reset release.
        rst_n = 1'b1;
        issue(dir_x[0], dir_y[0], 1'b1, 8, 12);
        wait_done();
        // Back-to-back: start presented during the done cycle.
        issue(dir_x[1], dir_y[1], 1'b1, 8, 12);
        wait_done();
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            issue(dir_x[k], dir_y[k], 1'b1, 8, 12);
            wait_done();
        end

        // A second start while busy must be ignored.
        @(negedge clk);
        issue(20000, -5000, 1'b1, 8, 12);
        repeat (3) @(negedge clk);
        start = 1'b1;
        x_in  = -16'sd30000;
        y_in  = 16'sd7000;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_ignored_start", busy == 1'b1, int'(busy), 1);
        wait_done();

        // Reset in the middle of an operation: outputs clear, no done follows.
        @(negedge clk);
        issue(12345, 6789, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy == 1'b0, int'(busy), 0);
        chk("midreset_done", done == 1'b0, int'(done), 0);
        chk("midreset_angle", angle == 16'sd0, int'(angle), 0);
        chk("midreset_magnitude", magnitude == 17'd0, int'({15'd0, magnitude}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        chk("idle_after_reset", busy == 1'b0, int'(busy), 0);

        // Randomized points with enough magnitude for a tight angle bound.
        for (int n = 0; n < 24; n++) begin
            do begin
                xv = int'($urandom_range(65535)) - 32768;
                yv = int'($urandom_range(65535)) - 32768;
            end while ((real'(xv) * xv + real'(yv) * yv) < 67108864.0);
            @(negedge clk);
            issue(xv, yv, 1'b1, 16, 24);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size() == 0, sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
